// File: rtl/melody_pkg.sv
// ============================================================================
// Module      : melody_pkg
// Description : Shared types and constants for the melody sequencer: ROM entry
//               layout, FSM state encoding, note half-periods at 100 MHz and
//               the song tables the note ROM is built from.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package melody_pkg;

  localparam int ENTRY_W = 24;
  localparam int BEATS_W = 4;
  localparam int PITCH_W = 20;

  localparam logic [BEATS_W-1:0] END_BEATS  = '0;
  localparam logic [PITCH_W-1:0] REST_PITCH = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Half-periods in 100 MHz clock cycles: 100e6 / (2 * f_note)
  localparam logic [PITCH_W-1:0] PITCH_C4 = 20'd191113;
  localparam logic [PITCH_W-1:0] PITCH_D4 = 20'd170262;
  localparam logic [PITCH_W-1:0] PITCH_E4 = 20'd151686;
  localparam logic [PITCH_W-1:0] PITCH_F4 = 20'd143173;
  localparam logic [PITCH_W-1:0] PITCH_G4 = 20'd127551;
  localparam logic [PITCH_W-1:0] PITCH_A4 = 20'd113636;
  localparam logic [PITCH_W-1:0] PITCH_B4 = 20'd101238;
  localparam logic [PITCH_W-1:0] PITCH_C5 = 20'd95556;
  localparam logic [PITCH_W-1:0] PITCH_C6 = 20'd47778;

  function automatic logic [ENTRY_W-1:0] mk(input logic [BEATS_W-1:0] beats,
                                            input logic [PITCH_W-1:0] pitch);
    return {beats, pitch};
  endfunction

  // Song tables. Any address not listed reads as the END marker.
  //   0 : production melody
  //   1 : short test song ending in END
  //   2 : two-entry song with no END, ends by running off the last address
  function automatic logic [ENTRY_W-1:0] song_word(input int song, input int idx);
    logic [ENTRY_W-1:0] w;
    w = {END_BEATS, REST_PITCH};
    case (song)
      0: case (idx)
        0:  w = mk(4'd1, PITCH_C4);
        1:  w = mk(4'd1, PITCH_C4);
        2:  w = mk(4'd1, PITCH_G4);
        3:  w = mk(4'd1, PITCH_G4);
        4:  w = mk(4'd1, PITCH_A4);
        5:  w = mk(4'd1, PITCH_A4);
        6:  w = mk(4'd2, PITCH_G4);
        7:  w = mk(4'd1, PITCH_F4);
        8:  w = mk(4'd1, PITCH_F4);
        9:  w = mk(4'd1, PITCH_E4);
        10: w = mk(4'd1, PITCH_E4);
        11: w = mk(4'd1, PITCH_D4);
        12: w = mk(4'd1, PITCH_D4);
        13: w = mk(4'd2, PITCH_C4);
        14: w = mk(4'd1, REST_PITCH);
        15: w = mk(4'd1, PITCH_B4);
        16: w = mk(4'd1, PITCH_C5);
        17: w = mk(4'd4, PITCH_C6);
        default: w = {END_BEATS, REST_PITCH};
      endcase
      1: case (idx)
        0: w = mk(4'd3, 20'h01000);
        1: w = mk(4'd1, 20'h00800);
        2: w = mk(4'd2, REST_PITCH);
        3: w = mk(4'd1, 20'h00400);
        default: w = {END_BEATS, REST_PITCH};
      endcase
      2: case (idx)
        0: w = mk(4'd1, 20'h00111);
        1: w = mk(4'd1, 20'h00222);
        default: w = {END_BEATS, REST_PITCH};
      endcase
      default: w = {END_BEATS, REST_PITCH};
    endcase
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/melody_sequencer_if.sv
// ============================================================================
// Module      : melody_sequencer_if
// Description : Control/status bundle between the button logic (master) and
//               the melody sequencer (slave).
//   start    m->s  one-cycle pulse, begin playback at entry 0
//   stop     m->s  one-cycle pulse, abort playback
//   loop_en  m->s  level, restart at entry 0 at end of song
//   speed    m->s  ticks per beat (0 treated as 1)
//   o_note   s->m  one-cycle half-period pulse for the Speaker
//   busy     s->m  high whenever not idle
//   done     s->m  one-cycle pulse at non-looping end of song
//   note_idx s->m  address of the current entry
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface melody_sequencer_if
  import melody_pkg::*;
#(
  parameter int ADDR_W = 6
);
  logic               start;
  logic               stop;
  logic               loop_en;
  logic [7:0]         speed;
  logic [PITCH_W-1:0] o_note;
  logic               busy;
  logic               done;
  logic [ADDR_W-1:0]  note_idx;

  modport master (
    output start, stop, loop_en, speed,
    input  o_note, busy, done, note_idx
  );

  modport slave (
    input  start, stop, loop_en, speed,
    output o_note, busy, done, note_idx
  );
endinterface

`default_nettype wire

// File: rtl/melody_sequencer_note_rom.sv
// ============================================================================
// Module      : note_rom
// Description : Synchronous-read song ROM, DEPTH x ENTRY_W, one cycle latency.
//   clk    in   system clock
//   addr_i in   read address
//   data_o out  entry {beats[3:0], pitch[19:0]}, registered
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_rom
  import melody_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int SONG   = 0
) (
  input  logic               clk,
  input  logic [ADDR_W-1:0]  addr_i,
  output logic [ENTRY_W-1:0] data_o
);

  logic [ENTRY_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (int'(addr_i) < DEPTH) data_q <= song_word(SONG, int'(addr_i));
    else                      data_q <= {END_BEATS, REST_PITCH};
  end

  assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/melody_sequencer.sv
// ============================================================================
// Module      : melody_sequencer
// Description : Walks the note ROM, emitting a one-cycle half-period pulse at
//               the start of every non-rest note and holding each entry for
//               beats * speed * TICK_CYCLES cycles.
//   clk   in   system clock
//   rst_n in   asynchronous active-low reset
//   bus   slave modport: start/stop/loop_en/speed in,
//                        o_note/busy/done/note_idx out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module melody_sequencer
  import melody_pkg::*;
#(
  parameter int TICK_CYCLES = 6250000,
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 6,
  parameter int SONG        = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  melody_sequencer_if.slave bus
);

  localparam int                TICK_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [7:0]          tib_q, tib_d;      // tick_in_beat
  logic [BEATS_W-1:0]  beat_q, beat_d;
  logic [BEATS_W-1:0]  beats_q, beats_d;
  logic [7:0]          speed_q, speed_d;
  logic [PITCH_W-1:0]  note_q, note_d;
  logic                done_q, done_d;

  logic [ENTRY_W-1:0]  rom_data;
  logic [BEATS_W-1:0]  rom_beats;
  logic [PITCH_W-1:0]  rom_pitch;
  logic                tick_wrap, beat_wrap, hold_end;

  note_rom #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .SONG   (SONG)
  ) u_rom (
    .clk    (clk),
    .addr_i (addr_q),
    .data_o (rom_data)
  );

  assign rom_beats = rom_data[ENTRY_W-1 -: BEATS_W];
  assign rom_pitch = rom_data[PITCH_W-1:0];

  // Nested wrap conditions: last tick of a beat, last beat of the entry.
  assign tick_wrap = (tick_q == TICK_LAST);
  assign beat_wrap = tick_wrap && (tib_q == speed_q - 8'd1);
  assign hold_end  = beat_wrap && (beat_q == beats_q - BEATS_W'(1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tick_d  = tick_q;
    tib_d   = tib_q;
    beat_d  = beat_q;
    beats_d = beats_q;
    speed_d = speed_q;
    note_d  = '0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d  = '0;
          state_d = FETCH;
        end
      end

      FETCH: state_d = ISSUE;

      ISSUE: begin
        if (rom_beats == END_BEATS) begin
          if (bus.loop_en) begin
            addr_d  = '0;
            state_d = FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          // A rest carries pitch 0, so no pulse reaches the Speaker.
          note_d  = rom_pitch;
          beats_d = rom_beats;
          speed_d = (bus.speed == 8'd0) ? 8'd1 : bus.speed;
          tick_d  = '0;
          tib_d   = '0;
          beat_d  = '0;
          state_d = HOLD;
        end
      end

      HOLD: begin
        tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
        if (tick_wrap) tib_d = beat_wrap ? 8'd0 : tib_q + 8'd1;
        if (beat_wrap) beat_d = beat_q + BEATS_W'(1);
        if (hold_end) begin
          tick_d = '0;
          tib_d  = '0;
          beat_d = '0;
          if (addr_q == ADDR_LAST) begin
            // Running off the table ends the song exactly like an END entry.
            if (bus.loop_en) begin
              addr_d  = '0;
              state_d = FETCH;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = FETCH;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // stop overrides everything, including a simultaneous start.
    if (bus.stop) begin
      state_d = IDLE;
      note_d  = '0;
      done_d  = 1'b0;
      tick_d  = '0;
      tib_d   = '0;
      beat_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      tick_q  <= '0;
      tib_q   <= '0;
      beat_q  <= '0;
      beats_q <= '0;
      speed_q <= '0;
      note_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tick_q  <= tick_d;
      tib_q   <= tib_d;
      beat_q  <= beat_d;
      beats_q <= beats_d;
      speed_q <= speed_d;
      note_q  <= note_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_note   = note_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.note_idx = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_melody_sequencer.sv
// ============================================================================
// Module      : tb_melody_sequencer
// Description : Self-checking bench for melody_sequencer. Two instances with
//               TICK_CYCLES=4: song 1 (END-terminated, DEPTH 64) and song 2
//               (no END, DEPTH 2). Expected pulse schedules come from an
//               event-time model of the song rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_melody_sequencer;

  localparam int TICK = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic       start_r, stop_r, loop_r;
  logic [7:0] speed_r;

  always #5 clk = ~clk;

  melody_sequencer_if #(.ADDR_W(6)) bus_a ();
  melody_sequencer_if #(.ADDR_W(1)) bus_b ();

  assign bus_a.start   = start_r & ~sel;
  assign bus_b.start   = start_r & sel;
  assign bus_a.stop    = stop_r;
  assign bus_b.stop    = stop_r;
  assign bus_a.loop_en = loop_r;
  assign bus_b.loop_en = loop_r;
  assign bus_a.speed   = speed_r;
  assign bus_b.speed   = speed_r;

  melody_sequencer #(.TICK_CYCLES(TICK), .DEPTH(64), .ADDR_W(6), .SONG(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  melody_sequencer #(.TICK_CYCLES(TICK), .DEPTH(2), .ADDR_W(1), .SONG(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  wire [19:0] w_note = sel ? bus_b.o_note : bus_a.o_note;
  wire        w_busy = sel ? bus_b.busy   : bus_a.busy;
  wire        w_done = sel ? bus_b.done   : bus_a.done;

  // Song contents as the bench understands them
  int A_BEATS [5] = '{3, 1, 2, 1, 0};
  int A_PITCH [5] = '{'h1000, 'h0800, 0, 'h0400, 0};
  int B_BEATS [2] = '{1, 1};
  int B_PITCH [2] = '{'h111, 'h222};

  typedef struct { int t; int v; } ev_t;
  ev_t obs_q[$];
  ev_t exp_q[$];
  int  obs_done, obs_done_cnt, exp_done;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Event-time model: t is the clock edge (counted from the edge that samples
  // start as edge 0) after which an entry's o_note/done value is visible.
  task automatic model(input bit s, input int spd, input bit lp, input int stop_at, input int window);
    int se, t, idx, depth, beats, pitch, stop_eff;
    exp_q.delete();
    exp_done = -1;
    se       = (spd == 0) ? 1 : spd;
    depth    = s ? 2 : 64;
    stop_eff = (stop_at == 0) ? (1 << 30) : stop_at;
    t   = 2;
    idx = 0;
    while (t <= window && t < stop_eff) begin
      beats = s ? B_BEATS[idx] : A_BEATS[idx];
      pitch = s ? B_PITCH[idx] : A_PITCH[idx];
      if (beats == 0) begin
        if (lp) begin
          idx = 0;
          t  += 2;
          continue;
        end
        exp_done = t;
        break;
      end
      if (pitch != 0) exp_q.push_back('{t, pitch});
      t += beats * se * TICK;
      if (idx == depth - 1) begin
        if (lp) idx = 0;
        else begin
          if (t <= window && t < stop_eff) exp_done = t;
          break;
        end
      end else begin
        idx++;
      end
      t += 2;
    end
  endtask

  task automatic run(input bit s, input int spd, input bit lp, input int stop_at,
                     input int restart_at, input int window);
    int prev_note;
    obs_q.delete();
    obs_done     = -1;
    obs_done_cnt = 0;
    prev_note    = 0;
    sel     = s;
    speed_r = 8'(spd);
    loop_r  = lp;
    @(negedge clk);
    start_r = 1'b1;
    for (int k = 0; k <= window; k++) begin
      @(negedge clk);
      start_r = 1'b0;
      stop_r  = 1'b0;
      if (w_note != 20'd0) begin
        check("no_back_to_back_pulse", prev_note, 0);
        obs_q.push_back('{k, int'(w_note)});
      end
      prev_note = int'(w_note);
      if (w_done) begin
        obs_done_cnt++;
        if (obs_done < 0) obs_done = k;
        check("busy_low_with_done", w_busy, 0);
      end
      if (stop_at > 0 && k == stop_at) check("busy_low_after_stop", w_busy, 0);
      if (k + 1 == stop_at)    stop_r  = 1'b1;
      if (k + 1 == restart_at) start_r = 1'b1;
    end
    @(negedge clk) stop_r = 1'b1;
    @(negedge clk) stop_r = 1'b0;
    @(negedge clk);
  endtask

  task automatic compare_model(input string tag);
    check($sformatf("%s n_pulses", tag), obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) begin
        check($sformatf("%s pulse%0d_edge", tag, i), obs_q[i].t, exp_q[i].t);
        check($sformatf("%s pulse%0d_val", tag, i), obs_q[i].v, exp_q[i].v);
      end
    end
    check($sformatf("%s done_edge", tag), obs_done, exp_done);
    check($sformatf("%s done_count", tag), obs_done_cnt, (exp_done >= 0) ? 1 : 0);
  endtask

  typedef struct {
    bit s; int spd; bit lp; int stop_at; int restart_at; int window;
    int exp_n; int exp_last; int exp_done;
  } vec_t;
  vec_t tv [10];

  initial begin
    int any_busy, any_note, last_t;
    int r_s, r_spd, r_lp, r_stop, r_rst;

    tv = '{
      '{1'b0, 2, 1'b0,  0, 0, 120, 3, 56, 66},   // nominal, 26-cycle spacing
      '{1'b0, 1, 1'b0,  0, 0, 120, 3, 32, 38},   // rest: next pulse 10 after rest issue
      '{1'b0, 0, 1'b0,  0, 0, 120, 3, 32, 38},   // speed 0 behaves as 1
      '{1'b0, 3, 1'b0,  0, 0, 120, 3, 80, 94},
      '{1'b0, 2, 1'b0, 10, 0, 120, 1,  2, -1},   // stop mid-HOLD
      '{1'b0, 1, 1'b1,  0, 0,  60, 5, 54, -1},   // loop through END
      '{1'b0, 1, 1'b0,  0, 8, 120, 3, 32, 38},   // start while busy ignored
      '{1'b1, 1, 1'b0,  0, 0,  40, 2,  8, 12},   // run off DEPTH-1
      '{1'b1, 1, 1'b1,  0, 0,  30, 5, 26, -1},   // wrap at DEPTH-1
      '{1'b0, 1, 1'b0,  2, 0,  40, 0, -1, -1}    // stop on the issue edge
    };

    sel = 1'b0; start_r = 1'b0; stop_r = 1'b0; loop_r = 1'b0; speed_r = 8'd1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset o_note", bus_a.o_note, 0);
    check("reset busy", bus_a.busy, 0);
    check("reset done", bus_a.done, 0);
    check("reset note_idx", bus_a.note_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after reset busy", bus_a.busy, 0);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      run(tv[i].s, tv[i].spd, tv[i].lp, tv[i].stop_at, tv[i].restart_at, tv[i].window);
      model(tv[i].s, tv[i].spd, tv[i].lp, tv[i].stop_at, tv[i].window);
      compare_model($sformatf("row%0d", i));
      last_t = (obs_q.size() > 0) ? obs_q[obs_q.size()-1].t : -1;
      check($sformatf("row%0d tbl_n", i), obs_q.size(), tv[i].exp_n);
      check($sformatf("row%0d tbl_last", i), last_t, tv[i].exp_last);
      check($sformatf("row%0d tbl_done", i), obs_done, tv[i].exp_done);
    end

    // start and stop in the same cycle: stays idle
    sel = 1'b0;
    @(negedge clk); start_r = 1'b1; stop_r = 1'b1;
    @(negedge clk); start_r = 1'b0; stop_r = 1'b0;
    check("start_stop busy", bus_a.busy, 0);
    any_busy = 0; any_note = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus_a.busy) any_busy = 1;
      if (bus_a.o_note != 20'd0) any_note = 1;
    end
    check("start_stop stays idle", any_busy, 0);
    check("start_stop no pulse", any_note, 0);

    // Asynchronous reset while o_note is pulsing mid-song
    speed_r = 8'd1; loop_r = 1'b0;
    @(negedge clk); start_r = 1'b1;
    @(negedge clk); start_r = 1'b0;
    repeat (16) @(negedge clk);
    check("pre_reset o_note", bus_a.o_note, 'h0800);
    check("pre_reset note_idx", bus_a.note_idx, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset o_note", bus_a.o_note, 0);
    check("async_reset busy", bus_a.busy, 0);
    check("async_reset note_idx", bus_a.note_idx, 0);
    check("async_reset done", bus_a.done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    any_busy = 0; any_note = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_a.busy) any_busy = 1;
      if (bus_a.o_note != 20'd0) any_note = 1;
    end
    check("post_reset stays idle", any_busy, 0);
    check("post_reset no pulse", any_note, 0);

    // Randomised runs against the model
    for (int i = 0; i < 16; i++) begin
      r_s   = int'($urandom_range(0, 1));
      r_spd = int'($urandom_range(0, 4));
      r_lp  = int'($urandom_range(0, 1));
      r_stop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, 100)) : 0;
      r_rst  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, 10)) : 0;
      if (r_stop != 0 && r_rst >= r_stop) r_rst = 0;
      run(r_s[0], r_spd, r_lp[0], r_stop, r_rst, 150);
      model(r_s[0], r_spd, r_lp[0], r_stop, 150);
      compare_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Drives the Speaker's note input: walks a note table in ROM and emits a one-cycle, non-zero 20-bit half-period pulse at the start of each note.
- Holds each note or rest for a programmable number of beats before advancing.
- Supports start and stop, looping, a tempo input and end-of-song detection.
- Sits between the top-level button/switch logic and the Speaker.

Parameters:
- TICK_CYCLES, 6250000: clk cycles per tempo tick (62.5 ms at 100 MHz).
- DEPTH, 64: number of ROM entries.
- ADDR_W, 6: ROM address width, equal to clog2(DEPTH).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins playback from entry 0
- stop  in  1  one-cycle pulse; aborts playback
- loop_en  in  1  level; restart at entry 0 at end of song
- speed  in  8  ticks per beat; 0 is treated as 1
- o_note  out  20  half-period pulse to the Speaker; non-zero for exactly one cycle per played note
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at a non-looping end of song
- note_idx  out  ADDR_W  address of the current entry

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: o_note=0, busy=0, done=0, note_idx=0, state=IDLE, all counters=0.
- ROM entry, 24 bits:
  - [23:20] beats; 0 is the END marker.
  - [19:0] pitch half-period; 0 is a rest.
- ROM read is synchronous with 1-cycle latency.
- State IDLE:
  - start -> FETCH with addr=0.
  - Otherwise remain in IDLE.
- State FETCH: drive addr; next cycle -> ISSUE. The data is valid in ISSUE.
- State ISSUE, decided in one cycle:
  - beats==0 with loop_en=1: addr=0 -> FETCH.
  - beats==0 with loop_en=0: done=1 for this cycle -> IDLE.
  - beats!=0: o_note=pitch for this cycle only. A rest therefore issues no pulse.
  - beats!=0: latch beats and speed_eff = (speed==0 ? 1 : speed); clear counters -> HOLD.
- State HOLD:
  - tick_cnt counts 0..TICK_CYCLES-1.
  - On wrap, tick_in_beat counts up; on reaching speed_eff, beat_cnt counts up.
  - When beat_cnt reaches the latched beats, leave HOLD.
  - Hold length is exactly beats*speed_eff*TICK_CYCLES cycles, counted from the ISSUE cycle to the last HOLD cycle.
- Leaving HOLD:
  - addr==DEPTH-1 with loop_en=1: addr=0 -> FETCH.
  - addr==DEPTH-1 with loop_en=0: go to ISSUE-equivalent end handling, which pulses done and goes to IDLE.
  - Otherwise: addr+1 -> FETCH.
- Per-note spacing from one o_note pulse to the next is hold + 2 cycles (FETCH, ISSUE).
- speed and loop_en:
  - speed is sampled only in ISSUE; changes mid-note take effect on the next note.
  - loop_en is sampled at end decisions.
- stop in any state: next state is IDLE, o_note=0, counters cleared, no done pulse.
- start and stop in the same cycle: stop wins.
- start while busy: ignored.
- Speaker interaction:
  - The Speaker retriggers on every non-zero pulse and self-silences after its fixed timeout.
  - Rests only suppress retrigger; they do not force silence.
- o_note is a registered output and is never non-zero for two consecutive cycles.
- busy=1 in FETCH, ISSUE and HOLD.
- Reset asserted mid-HOLD: all outputs return to reset values immediately (asynchronous). Playback restarts only on a new start.
- Counter widths:
  - tick_cnt: clog2(TICK_CYCLES).
  - tick_in_beat: 8 bits.
  - beat_cnt: 4 bits.

Decomposition:
- Shared package melody_pkg holds:
  - ENTRY_W=24, BEATS_W=4, PITCH_W=20
  - END_BEATS=0, REST_PITCH=0
  - state enum {IDLE, FETCH, ISSUE, HOLD}
  - pitch constants for the note names used by the song table (C4..C6 half-periods at 100 MHz)
- Sub-module note_rom: synchronous-read ROM of DEPTH x ENTRY_W, initialised from a song table. Song data stays out of the sequencer.

Test Plan:
- TICK_CYCLES=4, speed=2, ROM {beats 3/pitch 0x1000, beats 1/pitch 0x0800, END}, start pulse:
  - o_note=0x1000 for 1 cycle at start+2.
  - o_note=0x0800 for 1 cycle 26 cycles later (24-cycle hold + 2).
  - done pulse at end; busy falls the same cycle.
- Rest entry {beats 2, pitch 0} between two notes, speed=1, TICK_CYCLES=4: no pulse for the rest; the next pulse is 8+2 cycles after the rest's ISSUE.
- speed=0 with beats=1 and TICK_CYCLES=4: treated as speed 1; hold is 4 cycles.
- loop_en=1 on the three-entry song: after END, o_note=0x1000 reappears 2 cycles after the END ISSUE cycle, and done never pulses.
- stop mid-HOLD, and start+stop in the same cycle:
  - busy=0 next cycle; no further o_note pulses; no done.
  - The simultaneous case stays IDLE.
  - start while busy changes nothing.
- rst_n low mid-HOLD, asynchronously: o_note/busy/note_idx are 0 before the next clk edge. After release, the block stays idle until start.
